sequence_generator_tx: RTL and testbench
========================================

// Module: sequence_generator_tx
// PURPOSE
//  Bit-serial frame transmitter; the source end of the serial "1101" link
//  whose receive side is the overlapping sequence detector.
//  Accepts a parallel payload word over a valid/ready handshake and emits
//  each frame MSB-first on one serial line: PATTERN preamble, then payload,
//  then an idle gap.
//  Drives stimulus and loopback links toward the serial pattern detectors.
// PARAMETERS
//  DATA_W      8        payload width, bits (>=1)
//  PAT_W       4        preamble width, bits (>=1)
//  PATTERN     4'b1101  preamble value, sent MSB-first
//  GAP_CYCLES  2        idle cycles after each frame (0 = no gap state)
// PORTS
//  clk         in   1       single clock, all logic on posedge
//  rst         in   1       synchronous reset, active-high
//  load_valid  in   1       load_data is valid
//  load_data   in   DATA_W  payload word to send
//  load_ready  out  1       block can accept a word (state==IDLE)
//  out         out  1       serial bit, registered
//  out_valid   out  1       out carries a preamble or payload bit
//  frame_done  out  1       one-cycle pulse with the last payload bit
//  busy        out  1       state != IDLE
//  state_out   out  2       current FSM state (IDLE=0,PRE=1,PAY=2,GAP=3)
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE; out=0, out_valid=0, frame_done=0.
//   Counters and the shift register clear.
//   load_ready=1 and busy=0 in the cycle after the reset edge.
//   Reset mid-frame aborts the frame immediately; no partial-frame completion.
//  Handshake:
//   A word is accepted on a posedge with load_valid & load_ready.
//   load_ready is combinational: it equals (state==IDLE).
//   load_valid while busy is ignored and the word is not captured.
//   load_data must hold only at the accept edge.
//  FSM (state_out reflects it):
//   IDLE -> PRE on accept. Payload is latched.
//    out<=PATTERN[PAT_W-1], out_valid<=1, bit_cnt<=PAT_W-1.
//   PRE: one preamble bit per cycle, MSB-first, for PAT_W cycles total.
//    After the last preamble bit: out<=payload MSB, -> PAY.
//   PAY: one payload bit per cycle, MSB-first, for DATA_W cycles.
//    frame_done=1 in the same cycle that the last payload bit (LSB) is on out.
//   Leaving PAY: out<=0, out_valid<=0.
//    Next state is GAP if GAP_CYCLES>0, else IDLE.
//   GAP: stays GAP_CYCLES cycles with out=0, out_valid=0, then -> IDLE.
//  Latency: first preamble bit is valid in the cycle after the accept edge.
//   Frame occupies PAT_W+DATA_W consecutive out_valid cycles with no bubbles.
//   Accept-to-accept minimum period is PAT_W+DATA_W+GAP_CYCLES+1 cycles.
//  Widths: bit_cnt is $clog2(max(PAT_W,DATA_W)+1) bits and counts down.
//   Gap counter is $clog2(GAP_CYCLES+1) bits.
//   Both counters are unused and constant when they are not needed.
//  out is 0 whenever out_valid=0 (idle line level 0).
//  No combinational path from load_data to out. All outputs except
//   load_ready, busy and state_out are registered.
// TESTING
//  1. Reset then IDLE.
//   Stimulus: hold rst 2 cycles, load_valid=0.
//   Required: out=0, out_valid=0, load_ready=1, state_out=0.
//  2. Single frame.
//   Stimulus: load 8'hA5 at edge T.
//   Required: out in cycles T+1..T+12 = 1101_10100101, out_valid=1 throughout.
//    frame_done=1 only at T+12. out_valid=0 at T+13..T+14. load_ready=1 at T+15.
//  3. Busy ignore.
//   Stimulus: load 8'hA5, then assert load_valid with 8'hFF at T+3.
//   Required: the frame is unchanged and 8'hFF is never transmitted.
//  4. Back-to-back.
//   Stimulus: GAP_CYCLES=0, hold load_valid=1 with 8'h0F then 8'hF0.
//   Required: second accept occurs at T+13; the 1-cycle IDLE has out_valid=0.
//  5. Reset mid-frame.
//   Stimulus: assert rst at T+6 of an 8'hA5 frame.
//   Required: next cycle out=0, out_valid=0, state_out=0, frame_done never pulses.
//  6. Loopback.
//   Stimulus: drive out into a 1101 overlapping detector, payload 8'h00.
//   Required: exactly one detection, on the 4th preamble bit.

Source files
------------

// File: rtl/sequence_generator_tx.sv
// Bit-serial frame transmitter: PATTERN preamble, then payload, both MSB-first,
// followed by an optional idle gap. One frame per accepted valid/ready word.
module sequence_generator_tx #(
  parameter int                 DATA_W     = 8,
  parameter int                 PAT_W      = 4,
  parameter logic [PAT_W-1:0]   PATTERN    = 4'b1101,
  parameter int                 GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              out,
  output logic              out_valid,
  output logic              frame_done,
  output logic              busy,
  output logic [1:0]        state_out
);

  localparam int MAX_W = (PAT_W > DATA_W) ? PAT_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W + 1);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int FR_W  = PAT_W + DATA_W;

  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CNT_PAY  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_PAY  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              out_q, out_d;
  logic              vld_q, vld_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [FR_W-1:0]   frame_q, frame_d;
  logic              accept;

  assign load_ready = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign state_out  = state_q;
  assign out        = out_q;
  assign out_valid  = vld_q;
  assign frame_done = done_q;
  assign accept     = load_valid && load_ready;

  // The whole frame lives in one shift register; its MSB is always the next bit to send.
  always_comb begin
    state_d = state_q;
    out_d   = 1'b0;
    vld_d   = 1'b0;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    frame_d = frame_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_PRE;
          out_d   = PATTERN[PAT_W-1];
          vld_d   = 1'b1;
          cnt_d   = CNT_PRE;
          frame_d = {PATTERN, load_data} << 1;
        end
      end

      S_PRE: begin
        out_d   = frame_q[FR_W-1];
        vld_d   = 1'b1;
        frame_d = frame_q << 1;
        if (cnt_q == '0) begin
          state_d = S_PAY;
          cnt_d   = CNT_PAY;
          done_d  = (DATA_W == 1);
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
        end
      end

      S_PAY: begin
        if (cnt_q == '0) begin
          state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
          gap_d   = GAP_LAST;
          frame_d = '0;
        end else begin
          out_d   = frame_q[FR_W-1];
          vld_d   = 1'b1;
          frame_d = frame_q << 1;
          cnt_d   = cnt_q - CNT_ONE;
          done_d  = (cnt_q == CNT_ONE);
        end
      end

      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_d   = gap_q - GAP_ONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      out_q   <= 1'b0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      gap_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      frame_q <= frame_d;
    end
  end

endmodule

// File: tb/tb_sequence_generator_tx.sv
// Bench for sequence_generator_tx: two instances (gap of 2 and gap of 0) share
// stimulus; a frame-level model queues expected bits, a negedge monitor compares.
module tb_sequence_generator_tx;

  localparam int DW = 8;
  localparam int PW = 4;
  localparam logic [PW-1:0] PAT = 4'b1101;

  logic             clk = 1'b0;
  logic             rst;
  logic             lv;
  logic [DW-1:0]    ld;
  logic             rdy [2];
  logic             o   [2];
  logic             ov  [2];
  logic             fd  [2];
  logic             bsy [2];
  logic [1:0]       st  [2];

  always #5 clk = ~clk;

  sequence_generator_tx #(.DATA_W(DW), .PAT_W(PW), .PATTERN(PAT), .GAP_CYCLES(2)) dut_g2 (
    .clk(clk), .rst(rst), .load_valid(lv), .load_data(ld), .load_ready(rdy[0]),
    .out(o[0]), .out_valid(ov[0]), .frame_done(fd[0]), .busy(bsy[0]), .state_out(st[0])
  );

  sequence_generator_tx #(.DATA_W(DW), .PAT_W(PW), .PATTERN(PAT), .GAP_CYCLES(0)) dut_g0 (
    .clk(clk), .rst(rst), .load_valid(lv), .load_data(ld), .load_ready(rdy[1]),
    .out(o[1]), .out_valid(ov[1]), .frame_done(fd[1]), .busy(bsy[1]), .state_out(st[1])
  );

  int checks = 0;
  int errors = 0;

  // Expected serial stream per instance: {bit, is_last_payload_bit}
  logic [1:0] sq [2][$];
  int         bl [2];
  bit         mon_en = 1'b0;
  bit         det_en = 1'b0;
  logic [3:0] hist = 4'b0;
  int         det_cnt = 0;
  int         det_k = -1;

  function automatic int period(input int i);
    return PW + DW + ((i == 0) ? 2 : 0) + 1;
  endfunction

  task automatic chk(input string nm, input int i, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0d expected %0d at %0t", nm, i, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame-level model: an accepted word occupies the line for a fixed period.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        sq[i].delete();
        bl[i] = 0;
      end else if (bl[i] == 0 && lv) begin
        logic [PW-1:0] p;
        logic [DW-1:0] d;
        p = PAT;
        d = ld;
        for (int j = PW - 1; j >= 0; j--) sq[i].push_back({p[j], 1'b0});
        for (int j = DW - 1; j >= 0; j--) sq[i].push_back({d[j], (j == 0) ? 1'b1 : 1'b0});
        bl[i] = period(i) - 1;
      end else if (bl[i] > 0) begin
        bl[i] = bl[i] - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        int k;
        int es;
        bit evld;
        logic [1:0] e;
        k    = period(i) - bl[i];
        evld = (bl[i] != 0) && (k <= PW + DW);
        if (bl[i] == 0)         es = 0;
        else if (k <= PW)       es = 1;
        else if (k <= PW + DW)  es = 2;
        else                    es = 3;
        chk("state_out", i, int'(st[i]), es);
        chk("load_ready", i, int'(rdy[i]), (bl[i] == 0) ? 1 : 0);
        chk("busy", i, int'(bsy[i]), (bl[i] != 0) ? 1 : 0);
        chk("out_valid", i, int'(ov[i]), evld ? 1 : 0);
        if (evld) begin
          if (sq[i].size() == 0) begin
            chk("sb_underflow", i, 0, 1);
          end else begin
            e = sq[i].pop_front();
            chk("out_bit", i, int'(o[i]), int'(e[1]));
            chk("frame_done", i, int'(fd[i]), int'(e[0]));
          end
        end else begin
          chk("idle_out", i, int'(o[i]), 0);
          chk("idle_done", i, int'(fd[i]), 0);
        end
      end
      hist = {hist[2:0], o[0]};
      if (det_en && hist == 4'b1101) begin
        det_cnt++;
        det_k = period(0) - bl[0];
      end
    end
  end

  initial begin
    rst = 1'b1;
    lv  = 1'b0;
    ld  = '0;
    @(posedge clk);
    mon_en = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(2);

    // Single frame 8'hA5
    lv = 1'b1; ld = 8'hA5;
    tick(1);
    lv = 1'b0;
    tick(16);

    // Busy ignore: 8'hFF offered from T+3 while a frame is in flight
    lv = 1'b1; ld = 8'hA5;
    tick(1);
    lv = 1'b0;
    tick(2);
    lv = 1'b1; ld = 8'hFF;
    tick(5);
    lv = 1'b0;
    tick(16);

    // Back-to-back with load_valid held high
    lv = 1'b1; ld = 8'h0F;
    tick(1);
    ld = 8'hF0;
    tick(13);
    lv = 1'b0;
    tick(18);

    // Reset at T+6 of an A5 frame
    lv = 1'b1; ld = 8'hA5;
    tick(1);
    lv = 1'b0;
    tick(5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(16);

    // Loopback into an overlapping 1101 detector, payload 0
    det_cnt = 0;
    det_k   = -1;
    det_en  = 1'b1;
    lv = 1'b1; ld = 8'h00;
    tick(1);
    lv = 1'b0;
    tick(16);
    det_en = 1'b0;
    chk("loop_det_count", 0, det_cnt, 1);
    chk("loop_det_pos", 0, det_k, 4);

    // Randomized traffic with occasional resets
    repeat (400) begin
      rst = ($urandom_range(0, 79) == 0);
      lv  = ($urandom_range(0, 2) == 0);
      ld  = DW'($urandom);
      tick(1);
    end
    rst = 1'b0;
    lv  = 1'b0;
    tick(20);
    chk("sb_drain", 0, sq[0].size(), 0);
    chk("sb_drain", 1, sq[1].size(), 0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
